// File: rtl/mux_scan_sel_if.sv
// Bus bundle for mux_scan_sel: source side (data, selects, enables, mode,
// start) and the registered output side with its valid/ready handshake.
//   en_n       CH          per-channel enable, active-low
//   mode       1           0 = direct select, 1 = auto-scan
//   sel        SEL_W       input index used in direct mode
//   start      1           scan start pulse
//   din        CH*NIN*W    channel c, input i at [(c*NIN+i)*W +: W]
//   dout       CH*W        registered selected word, channel c at [c*W +: W]
//   dout_valid 1           dout/dout_idx hold a valid word
//   dout_ready 1           sink accepts the word
//   dout_idx   SEL_W       input index dout was taken from
//   busy       1           scan in progress
// The slave modport is the selector's view; master is the driver/sink view.
interface mux_scan_sel_if #(
  parameter int CH    = 2,
  parameter int SEL_W = 2,
  parameter int W     = 1
) ();
  localparam int NIN = 1 << SEL_W;

  logic [CH-1:0]       en_n;
  logic                mode;
  logic [SEL_W-1:0]    sel;
  logic                start;
  logic [CH*NIN*W-1:0] din;
  logic [CH*W-1:0]     dout;
  logic                dout_valid;
  logic                dout_ready;
  logic [SEL_W-1:0]    dout_idx;
  logic                busy;

  modport master (
    output en_n, mode, sel, start, din, dout_ready,
    input  dout, dout_valid, dout_idx, busy
  );

  modport slave (
    input  en_n, mode, sel, start, din, dout_ready,
    output dout, dout_valid, dout_idx, busy
  );
endinterface

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: CH independent N:1 selectors (N = 2**SEL_W, W bits each)
// with a shared registered output stage and valid/ready handshake.
// In direct mode every accepted cycle loads the word chosen by sel; in
// auto-scan mode a start pulse walks indices 0..N-1, one word per index.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mux_scan_sel_if slave modport (see interface for signal list)
// All outputs come straight from registers.
module mux_scan_sel #(
  parameter int CH    = 2,
  parameter int SEL_W = 2,
  parameter int W     = 1
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_sel_if.slave  bus
);
  localparam int NIN = 1 << SEL_W;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [CH*W-1:0]  dout_q, dout_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] idx_q, idx_d;

  logic             avail;
  logic             load;
  logic [SEL_W-1:0] curIdx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    idx_d   = idx_q;

    // In IDLE with mode=1 nothing is selectable; a start pulse there only
    // arms the scan, and the first scan word loads on the following edge.
    avail  = (state_q == SCAN) || ((state_q == IDLE) && !bus.mode);
    load   = avail && (!valid_q || bus.dout_ready);
    curIdx = (state_q == SCAN) ? cnt_q : bus.sel;

    if (load) begin
      // Disabled channels still emit a (zero) word so all channels stay
      // aligned to dout_idx.
      for (int c = 0; c < CH; c++) begin
        dout_d[c*W +: W] = bus.en_n[c] ? '0
                         : bus.din[(c*NIN + int'(curIdx))*W +: W];
      end
      idx_d   = curIdx;
      valid_d = 1'b1;
      if (state_q == SCAN) begin
        // The counter is all ones on the last index, so the increment wraps
        // it back to zero exactly when the scan completes.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = IDLE;
        end
      end
    end else if (bus.dout_ready) begin
      valid_d = 1'b0;
    end

    if ((state_q == IDLE) && bus.start && bus.mode) begin
      state_d = SCAN;
      cnt_d   = '0;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.dout_idx   = idx_q;
  assign bus.busy       = (state_q == SCAN);
endmodule
